cl_sdp_axi_slv: RTL

//  AXI4 slave responder backed by an on-chip word-addressed SRAM. It is the target end of the
//  sdp driver's AXI master port: it stands in for DRAM/storage in sdp get/put loopback and

---
 rtl/sdp_axi_pkg.sv | 13 +
 rtl/sdp_axi_slv_mem.sv | 22 ++
 rtl/cl_sdp_axi_slv.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sdp_axi_pkg.sv
// sdp_axi_pkg: shared AXI response codes, slave FSM state types and index-width helpers
package sdp_axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  function automatic int lsb_of(input int dw);
    return $clog2(dw / 8);
  endfunction
  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sdp_axi_slv_mem.sv
// sdp_axi_slv_mem: 1W byte-enable / 1R SRAM with registered read-first output, no reset
module sdp_axi_slv_mem #(
  parameter int DW    = 64,
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < DW / 8; i++)
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  end
endmodule

// File: rtl/cl_sdp_axi_slv.sv
// cl_sdp_axi_slv: AXI4 INCR-burst slave over on-chip SRAM; SDP_AXI_SLV_RANGE_CHK_EN turns on out-of-range SLVERR
module cl_sdp_axi_slv
  import sdp_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);
  localparam int LSB   = lsb_of(AXI_DATA_WIDTH);
  localparam int IDX_W = idx_w_of(MEM_DEPTH);
  localparam int CW    = IDX_W + 9;
`ifdef SDP_AXI_SLV_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  wr_state_e w_st;
  rd_state_e r_st;
  logic [IDX_W-1:0] w_idx, r_idx, aw_idx, ar_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_err, w_oor, r_oor, w_hs, r_hs, w_last_beat, w_err_nxt, mem_re;
  logic [AXI_DATA_WIDTH-1:0] mem_rdata;
  logic unused_ok;
  function automatic logic oor(input logic [IDX_W-1:0] idx, input logic [7:0] len);
    return RANGE_CHK && (CW'(idx) + CW'(len) > CW'(MEM_DEPTH - 1));
  endfunction
  assign aw_idx      = s_axi_awaddr[LSB +: IDX_W];
  assign ar_idx      = s_axi_araddr[LSB +: IDX_W];
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign w_last_beat = w_cnt == w_len;
  assign w_err_nxt   = w_err || (s_axi_wlast != w_last_beat);
  assign mem_re      = r_st == R_ADDR || (r_hs && !s_axi_rlast);
  assign s_axi_rdata = r_oor ? '0 : mem_rdata;
  assign unused_ok   = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst, s_axi_awaddr, s_axi_araddr};
  sdp_axi_slv_mem #(.DW(AXI_DATA_WIDTH), .DEPTH(MEM_DEPTH), .IW(IDX_W)) u_mem (
    .clk   (clk),
    .we    (w_hs && !w_oor),
    .waddr (w_idx),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (mem_re),
    .raddr (r_idx),
    .rdata (mem_rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      w_st          <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= AXI_RESP_OKAY;
    end else begin
      case (w_st)
        W_IDLE:
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_bid     <= s_axi_awid;
            w_idx         <= aw_idx;
            w_len         <= s_axi_awlen;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            w_oor         <= oor(aw_idx, s_axi_awlen);
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_st          <= W_DATA;
          end else s_axi_awready <= 1'b1;
        W_DATA:
          if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err_nxt;
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err_nxt || w_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              w_st         <= W_RESP;
            end
          end
        W_RESP:
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_st          <= W_IDLE;
          end
        default: w_st <= W_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_st          <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= AXI_RESP_OKAY;
    end else begin
      case (r_st)
        R_IDLE:
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rid     <= s_axi_arid;
            r_idx         <= ar_idx;
            r_len         <= s_axi_arlen;
            r_oor         <= oor(ar_idx, s_axi_arlen);
            s_axi_rresp   <= oor(ar_idx, s_axi_arlen) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            s_axi_arready <= 1'b0;
            r_st          <= R_ADDR;
          end else s_axi_arready <= 1'b1;
        R_ADDR: begin
          r_idx        <= r_idx + 1'b1;
          r_cnt        <= '0;
          s_axi_rvalid <= 1'b1;
          s_axi_rlast  <= r_len == 8'd0;
          r_st         <= R_DATA;
        end
        R_DATA:
          if (r_hs && s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            r_st          <= R_IDLE;
          end else if (r_hs) begin
            r_idx       <= r_idx + 1'b1;
            r_cnt       <= r_cnt + 8'd1;
            s_axi_rlast <= r_cnt + 8'd1 == r_len;
          end
        default: r_st <= R_IDLE;
      endcase
    end
endmodule
